// File: rtl/ddr_burst_ctrl_pkg.sv
// Shared types and helpers for the DDR burst bridge: FSM encoding and burst sizing functions.
package ddr_burst_pkg;

    typedef enum logic [2:0] {
        WAIT_READY,
        IDLE,
        WFILL,
        WBURST,
        RREQ,
        RDATA
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic [31:0] burst_mask(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/ddr_burst_ctrl_if.sv
// Local (Avalon-style) side of the DDR controller: request, write data and read return channels.
interface ddr_burst_ctrl_if
    import ddr_burst_pkg::*;
#(
    parameter int ADDR_WIDTH     = 25,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_BURST_LOG2 = 4
);
    localparam int LAW = ADDR_WIDTH - clog2(DATA_WIDTH / 8);

    // A request beat (write_req or read_req high) transfers on every cycle where local_ready_i is
    // also high; the master holds address, size, data and byte enables stable until then.
    // Read data has no back-pressure: each cycle with local_rdata_valid_i high is one beat.
    logic [LAW-1:0]            local_address_o;
    logic                      local_write_req_o;
    logic                      local_read_req_o;
    logic                      local_burstbegin_o;
    logic [DATA_WIDTH-1:0]     local_wdata_o;
    logic [DATA_WIDTH/8-1:0]   local_be_o;
    logic [MAX_BURST_LOG2:0]   local_size_o;
    logic [DATA_WIDTH-1:0]     local_rdata_i;
    logic                      local_rdata_valid_i;
    logic                      local_ready_i;

    modport master (
        output local_address_o, local_write_req_o, local_read_req_o, local_burstbegin_o,
               local_wdata_o, local_be_o, local_size_o,
        input  local_rdata_i, local_rdata_valid_i, local_ready_i
    );

    modport slave (
        input  local_address_o, local_write_req_o, local_read_req_o, local_burstbegin_o,
               local_wdata_o, local_be_o, local_size_o,
        output local_rdata_i, local_rdata_valid_i, local_ready_i
    );

endinterface

// File: rtl/ddr_burst_fifo.sv
// Write-beat FIFO: holds {data, byte enables} between the fill phase and the local write burst.
module ddr_burst_fifo #(
    parameter int WIDTH      = 36,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]        mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]     count_q, count_d;
    logic                    do_push, do_pop;

    // Count never exceeds DEPTH, so its top bit alone marks full.
    assign full_o  = count_q[DEPTH_LOG2];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = do_push ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (DEPTH_LOG2 + 1)'(1);
        end else if (!do_push && do_pop) begin
            count_d = count_q - (DEPTH_LOG2 + 1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ddr_burst_ctrl.sv
// Burst bridge from the internal access port to the DDR controller local interface.
// Writes are gathered into the beat FIFO and issued as one burst; reads issue one burst request.
module ddr_burst_ctrl
    import ddr_burst_pkg::*;
#(
    parameter int ADDR_WIDTH     = 25,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_BURST_LOG2 = 4
) (
    input  logic                      local_clk_i,
    input  logic                      local_reset_n_i,
    input  logic                      acc_i,
    input  logic                      we_i,
    input  logic [31:0]               adr_i,
    input  logic [DATA_WIDTH-1:0]     dat_i,
    input  logic [DATA_WIDTH/8-1:0]   sel_i,
    input  logic [3:0]                buf_width_i,
    output logic                      ack_o,
    output logic [DATA_WIDTH-1:0]     dat_o,
    output logic [31:0]               adr_o,
    output logic                      idle_o,
    output logic                      rdy_o,
    output state_e                    state_dbg_o,
    ddr_burst_ctrl_if.master          lif
);
    localparam int B   = DATA_WIDTH / 8;
    localparam int BL2 = clog2(B);
    localparam int LAW = ADDR_WIDTH - BL2;
    localparam int SW  = MAX_BURST_LOG2 + 1;
    localparam int FW  = DATA_WIDTH + B;

    state_e            state_q, state_d;
    logic [LAW-1:0]    base_q, base_d;
    logic [SW-1:0]     n_q, n_d;
    logic [SW-1:0]     cnt_q, cnt_d;
    logic [SW-1:0]     size_q, size_d;
    logic [31:0]       adr_q, adr_d;
    logic              wreq_q, wreq_d;
    logic              rreq_q, rreq_d;
    logic              bb_q, bb_d;
    logic              idle_q, idle_d;

    int                w_eff;
    logic [31:0]       word_mask, byte_mask;
    logic [SW-1:0]     n_new;
    logic              fill_push, burst_pop;
    logic              fifo_full, fifo_empty;
    logic [SW-1:0]     fifo_count;
    logic [FW-1:0]     fifo_head;

    assign fill_push = (state_q == WFILL) && acc_i && we_i && !fifo_full;
    assign burst_pop = (state_q == WBURST) && lif.local_ready_i && !fifo_empty;

    ddr_burst_fifo #(
        .WIDTH      (FW),
        .DEPTH_LOG2 (MAX_BURST_LOG2)
    ) u_fifo (
        .clk_i       (local_clk_i),
        .rst_n_i     (local_reset_n_i),
        .push_i      (fill_push),
        .push_data_i ({dat_i, sel_i}),
        .pop_i       (burst_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign ack_o = ((state_q == WFILL) && acc_i && we_i) ||
                   ((state_q == RDATA) && acc_i && lif.local_rdata_valid_i);
    assign dat_o       = lif.local_rdata_i;
    assign adr_o       = adr_q;
    assign idle_o      = idle_q;
    assign rdy_o       = lif.local_ready_i;
    assign state_dbg_o = state_q;

    assign lif.local_address_o    = base_q;
    assign lif.local_write_req_o  = wreq_q;
    assign lif.local_read_req_o   = rreq_q;
    assign lif.local_burstbegin_o = bb_q;
    assign lif.local_size_o       = size_q;
    assign lif.local_wdata_o      = fifo_head[FW-1:B];
    assign lif.local_be_o         = fifo_head[B-1:0];

    always_comb begin
        w_eff     = (int'(buf_width_i) > MAX_BURST_LOG2) ? MAX_BURST_LOG2 : int'(buf_width_i);
        word_mask = burst_mask(w_eff);
        byte_mask = (word_mask << BL2) | 32'(B - 1);
        n_new     = SW'(32'd1 << w_eff);

        state_d = state_q;
        base_d  = base_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        adr_d   = adr_q;

        case (state_q)
            WAIT_READY: begin
                if (lif.local_ready_i) state_d = IDLE;
            end
            IDLE: begin
                if (acc_i) begin
                    base_d  = LAW'((adr_i >> BL2) & ~word_mask);
                    adr_d   = adr_i & ~byte_mask;
                    n_d     = n_new;
                    size_d  = n_new;
                    cnt_d   = '0;
                    state_d = we_i ? WFILL : RREQ;
                end
            end
            WFILL: begin
                if (fill_push) begin
                    cnt_d = cnt_q + SW'(1);
                    if (cnt_q + SW'(1) == n_q) state_d = WBURST;
                end else if (!acc_i) begin
                    // An early drop turns whatever was collected into a short burst.
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        size_d  = cnt_q;
                        state_d = WBURST;
                    end
                end
            end
            WBURST: begin
                if (burst_pop && fifo_count == SW'(1)) state_d = IDLE;
            end
            RREQ: begin
                if (lif.local_ready_i) begin
                    cnt_d   = '0;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                // Beats keep arriving even if the requester lost interest; count them all.
                if (lif.local_rdata_valid_i) begin
                    cnt_d = cnt_q + SW'(1);
                    adr_d = adr_q + 32'(B);
                    if (cnt_q + SW'(1) == n_q) state_d = IDLE;
                end
            end
            default: state_d = WAIT_READY;
        endcase

        wreq_d = (state_d == WBURST);
        rreq_d = (state_d == RREQ);
        idle_d = (state_d == IDLE);
        case (state_d)
            WBURST:  bb_d = (state_q != WBURST) ? 1'b1 : (bb_q && !lif.local_ready_i);
            RREQ:    bb_d = 1'b1;
            default: bb_d = 1'b0;
        endcase
    end

    always_ff @(posedge local_clk_i or negedge local_reset_n_i) begin
        if (!local_reset_n_i) begin
            state_q <= WAIT_READY;
            base_q  <= '0;
            n_q     <= SW'(1);
            cnt_q   <= '0;
            size_q  <= SW'(1);
            adr_q   <= '0;
            wreq_q  <= 1'b0;
            rreq_q  <= 1'b0;
            bb_q    <= 1'b0;
            idle_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            adr_q   <= adr_d;
            wreq_q  <= wreq_d;
            rreq_q  <= rreq_d;
            bb_q    <= bb_d;
            idle_q  <= idle_d;
        end
    end

endmodule

// File: tb/tb_ddr_burst_ctrl.sv
// Directed scoreboard bench for ddr_burst_ctrl: expected events queued by the drivers,
// consumed by an independent negedge monitor.
module tb_ddr_burst_ctrl;
    import ddr_burst_pkg::*;

    localparam int AW  = 25;
    localparam int DW  = 32;
    localparam int MBL = 4;
    localparam int EW  = 98;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          acc_i, we_i;
    logic [31:0]   adr_i, dat_i;
    logic [3:0]    sel_i, buf_width_i;
    logic          ack_o;
    logic [31:0]   dat_o, adr_o;
    logic          idle_o, rdy_o;
    state_e        state_dbg;

    logic [EW-1:0] exp_q[$];
    int            n_pass = 0;
    int            n_total = 0;

    ddr_burst_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST_LOG2(MBL)) lif ();

    ddr_burst_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST_LOG2(MBL)) dut (
        .local_clk_i     (clk),
        .local_reset_n_i (rst_n),
        .acc_i           (acc_i),
        .we_i            (we_i),
        .adr_i           (adr_i),
        .dat_i           (dat_i),
        .sel_i           (sel_i),
        .buf_width_i     (buf_width_i),
        .ack_o           (ack_o),
        .dat_o           (dat_o),
        .adr_o           (adr_o),
        .idle_o          (idle_o),
        .rdy_o           (rdy_o),
        .state_dbg_o     (state_dbg),
        .lif             (lif)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    // ---------------- helpers ----------------
    function automatic logic [EW-1:0] mk(input logic [1:0] k, input logic [31:0] a,
                                         input logic [31:0] b, input logic [31:0] c);
        return {k, a, b, c};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic sb_check(input string name, input logic [EW-1:0] act);
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: got %h required no event", name, act);
        end else begin
            check(name, act, exp_q.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while (!idle_o && cyc < 40) begin
            step();
            cyc++;
        end
        check(name, EW'(idle_o), EW'(1));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            if (lif.local_write_req_o && lif.local_ready_i)
                sb_check("wbeat", mk(2'd1, 32'(lif.local_address_o),
                         32'({lif.local_size_o, lif.local_burstbegin_o, lif.local_be_o}),
                         lif.local_wdata_o));
            if (lif.local_read_req_o && lif.local_ready_i)
                sb_check("rreq", mk(2'd2, 32'(lif.local_address_o),
                         32'({lif.local_size_o, lif.local_burstbegin_o, 4'h0}), 32'h0));
            if (ack_o)
                sb_check("ack", we_i ? mk(2'd3, 32'h0, 32'h1, dat_i)
                                     : mk(2'd3, adr_o, 32'h0, dat_o));
        end
    end

    // ---------------- drivers ----------------
    task automatic do_write(input logic [31:0] a, input logic [3:0] bw, input int nsend,
                            input logic [31:0] d0, input logic [15:0] stall,
                            input logic [31:0] exp_word, input int exp_n);
        int k, cyc;
        k = (nsend < exp_n) ? nsend : exp_n;
        for (int i = 0; i < k; i++) exp_q.push_back(mk(2'd3, 32'h0, 32'h1, d0 + 32'(i)));
        for (int i = 0; i < k; i++)
            exp_q.push_back(mk(2'd1, exp_word, 32'({5'(k), (i == 0), ~4'(i)}), d0 + 32'(i)));
        acc_i = 1'b1; we_i = 1'b1; adr_i = a; buf_width_i = bw; dat_i = d0; sel_i = 4'hF;
        step();
        for (int i = 0; i < k; i++) begin
            dat_i = d0 + 32'(i);
            sel_i = ~4'(i);
            step();
        end
        acc_i = 1'b0; we_i = 1'b0;
        if (k == exp_n) check("wlat", EW'(lif.local_write_req_o), EW'(1));
        cyc = 0;
        while (!lif.local_write_req_o && cyc < 8) begin
            step();
            cyc++;
        end
        check("wreq_seen", EW'(lif.local_write_req_o), EW'(1));
        for (int j = 0; j < k; j++) begin
            if (stall[j]) begin
                lif.local_ready_i = 1'b0;
                step();
                lif.local_ready_i = 1'b1;
            end
            step();
        end
        wait_idle("w_idle");
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] bw, input int rstall,
                           input logic [31:0] d0, input int ack_beats,
                           input logic [31:0] exp_word, input int exp_n,
                           input logic [31:0] exp_base);
        exp_q.push_back(mk(2'd2, exp_word, 32'({5'(exp_n), 1'b1, 4'h0}), 32'h0));
        for (int j = 0; j < exp_n && j < ack_beats; j++)
            exp_q.push_back(mk(2'd3, exp_base + 32'(4 * j), 32'h0, d0 + 32'(j)));
        acc_i = 1'b1; we_i = 1'b0; adr_i = a; buf_width_i = bw;
        lif.local_ready_i = 1'b0;
        step();
        for (int s = 0; s < rstall; s++) begin
            lif.local_rdata_valid_i = 1'b1;
            #1;
            check("rreq_held",
                  EW'({lif.local_read_req_o, lif.local_burstbegin_o, ack_o, rdy_o,
                       32'(lif.local_address_o), 32'(lif.local_size_o)}),
                  EW'({1'b1, 1'b1, 1'b0, 1'b0, exp_word, 32'(exp_n)}));
            step();
        end
        lif.local_rdata_valid_i = 1'b0;
        lif.local_ready_i = 1'b1;
        step();
        for (int j = 0; j < exp_n; j++) begin
            acc_i = (j < ack_beats);
            if (j == exp_n / 2) begin
                lif.local_rdata_valid_i = 1'b0;
                step();
            end
            lif.local_rdata_valid_i = 1'b1;
            lif.local_rdata_i = d0 + 32'(j);
            step();
        end
        lif.local_rdata_valid_i = 1'b0;
        acc_i = 1'b0;
        wait_idle("r_idle");
    endtask

    // ---------------- main sequence ----------------
    initial begin
        acc_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0; sel_i = '0; buf_width_i = '0;
        lif.local_ready_i = 1'b0; lif.local_rdata_i = '0; lif.local_rdata_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", EW'(state_dbg), EW'(WAIT_READY));
        check("rst_wreq", EW'(lif.local_write_req_o), EW'(0));
        check("rst_rreq", EW'(lif.local_read_req_o), EW'(0));
        check("rst_bb", EW'(lif.local_burstbegin_o), EW'(0));
        check("rst_ack", EW'(ack_o), EW'(0));
        check("rst_size", EW'(lif.local_size_o), EW'(1));
        check("rst_adr_o", EW'(adr_o), EW'(0));
        check("rst_laddr", EW'(lif.local_address_o), EW'(0));

        rst_n = 1'b1;
        lif.local_ready_i = 1'b1;
        @(negedge clk);
        check("idle_first", EW'(idle_o), EW'(0));
        step();
        check("idle_second", EW'(idle_o), EW'(1));
        check("rdy_o", EW'(rdy_o), EW'(1));

        do_write(32'h104, 4'd2, 4, 32'hA0, 16'h0000, 32'h40, 4);
        do_write(32'h104, 4'd2, 4, 32'hA0, 16'h0006, 32'h40, 4);
        do_read(32'h220, 4'd3, 2, 32'hD000_0000, 8, 32'h88, 8, 32'h220);
        do_write(32'h300, 4'd2, 2, 32'hB0, 16'h0000, 32'hC0, 4);
        do_write(32'h1234, 4'd7, 16, 32'hE0, 16'h0001, 32'h480, 16);
        do_read(32'h0, 4'd2, 1, 32'hF0, 2, 32'h0, 4, 32'h0);

        // reset in the middle of a read burst
        exp_q.push_back(mk(2'd2, 32'h10, 32'({5'd4, 1'b1, 4'h0}), 32'h0));
        for (int j = 0; j < 3; j++) exp_q.push_back(mk(2'd3, 32'h40 + 32'(4 * j), 32'h0, 32'h5A00 + 32'(j)));
        acc_i = 1'b1; we_i = 1'b0; adr_i = 32'h40; buf_width_i = 4'd2;
        step();
        step();
        for (int j = 0; j < 3; j++) begin
            lif.local_rdata_valid_i = 1'b1;
            lif.local_rdata_i = 32'h5A00 + 32'(j);
            step();
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_rreq", EW'(lif.local_read_req_o), EW'(0));
        check("arst_ack", EW'(ack_o), EW'(0));
        check("arst_adr_o", EW'(adr_o), EW'(0));
        check("arst_laddr", EW'(lif.local_address_o), EW'(0));
        check("arst_size", EW'(lif.local_size_o), EW'(1));
        check("arst_idle", EW'(idle_o), EW'(0));
        acc_i = 1'b0;
        lif.local_rdata_valid_i = 1'b0;
        lif.local_ready_i = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        check("wait_ready_hold", EW'(idle_o), EW'(0));
        lif.local_ready_i = 1'b1;
        wait_idle("rst_recover");
        do_read(32'h10, 4'd1, 0, 32'h7700, 2, 32'h4, 2, 32'h10);

        step();
        check("sb_drain", EW'(exp_q.size()), EW'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ddr_burst_ctrl.md
Name: ddr_burst_ctrl

Overview:
Parametrised successor to the single-beat DDR local-interface bridge. It sits between the internal cache/bus-side access port and the Altera DDR controller local (Avalon-style) interface. It issues true write bursts from an internal beat FIFO and read bursts of up to 2^MAX_BURST_LOG2 beats. Data width, burst depth and address width are generic. It honours local_ready_i back-pressure on every request beat, which the previous block did not.

Parameters:
ADDR_WIDTH, 25, byte address bits of the memory (2^ADDR_WIDTH bytes).
DATA_WIDTH, 32, local and internal data width; power of two, at least 8.
MAX_BURST_LOG2, 4, log2 of the maximum burst beats; also the log2 of the write FIFO depth.

Ports:
local_clk_i  in  1  sole clock.
local_reset_n_i  in  1  reset, asynchronous assert, active-low.
acc_i  in  1  access request from the internal side.
we_i  in  1  1 = write, 0 = read; sampled in IDLE.
adr_i  in  32  byte address.
dat_i  in  DATA_WIDTH  write data beat.
sel_i  in  DATA_WIDTH/8  byte enables of the write beat.
buf_width_i  in  4  log2 of the burst beat count; clamped to MAX_BURST_LOG2.
ack_o  out  1  beat accepted (write) or beat valid (read).
dat_o  out  DATA_WIDTH  read beat data.
adr_o  out  32  byte address of the current read beat.
idle_o  out  1  FSM is in IDLE.
rdy_o  out  1  equal to local_ready_i.
local_address_o  out  ADDR_WIDTH-log2(DATA_WIDTH/8)  word address of the burst base.
local_write_req_o  out  1  write request.
local_read_req_o  out  1  read request.
local_burstbegin_o  out  1  first beat of a burst.
local_wdata_o  out  DATA_WIDTH  write data, taken from the FIFO head.
local_be_o  out  DATA_WIDTH/8  write byte enables, taken from the FIFO head.
local_size_o  out  MAX_BURST_LOG2+1  burst length in beats.
local_rdata_i  in  DATA_WIDTH  read data from the controller.
local_rdata_valid_i  in  1  read data valid.
local_ready_i  in  1  controller accepts the current request beat.

Behaviour:
- Reset (asynchronous): state = WAIT_READY.
  - All req, burstbegin and ack outputs 0; local_size_o = 1; adr_o = 0; local_address_o = 0.
  - FIFO emptied; beat counters cleared.
  - A reset asserted mid-burst abandons the burst immediately; no further req is driven.
- Definitions: W = min(buf_width_i, MAX_BURST_LOG2), N = 2^W, B = DATA_WIDTH/8.
  - Burst base = adr_i aligned down to N*B bytes, latched on leaving IDLE.
- WAIT_READY -> IDLE when local_ready_i = 1.
- IDLE, acc_i = 1:
  - we_i = 1 -> WFILL; latch base and N.
  - we_i = 0 -> RREQ; latch base and N.
  - No ack_o is driven in IDLE.
- WFILL:
  - ack_o = acc_i & we_i, combinational.
  - Each acked beat pushes {dat_i, sel_i} into the FIFO; beats map to words base, base+1, ... in order.
  - After the N-th push -> WBURST.
  - If acc_i drops with k >= 1 beats pushed -> WBURST with local_size_o = k (short burst).
  - If acc_i drops with k = 0 -> IDLE.
- WBURST:
  - local_write_req_o = 1; local_wdata_o and local_be_o come from the FIFO head.
  - local_burstbegin_o = 1 only until the first beat is accepted.
  - A beat is accepted and popped on each cycle with local_ready_i = 1.
  - local_address_o and local_size_o stay stable for the whole burst.
  - FIFO empty after the last accepted beat -> IDLE.
- RREQ:
  - local_read_req_o = 1, local_burstbegin_o = 1, local_size_o = N.
  - Both held until local_ready_i = 1, then -> RDATA.
- RDATA:
  - ack_o = acc_i & local_rdata_valid_i; dat_o = local_rdata_i.
  - adr_o starts at the base and advances by B per valid beat.
  - After N valid beats -> IDLE.
  - If acc_i drops, the remaining beats are drained with ack_o = 0 and the FSM still waits for all N.
- local_rdata_valid_i outside RDATA is ignored.
- The FIFO never overflows, because the push count is capped at N, which is at most the FIFO depth.
- Latency:
  - Write: first local beat one cycle after the last fill ack.
  - Read: request on the cycle after IDLE accept.

Decomposition:
- Package ddr_burst_pkg holds:
  - FSM state encodings: WAIT_READY, IDLE, WFILL, WBURST, RREQ, RDATA.
  - Function clog2.
  - Function burst_mask(W) = (1<<W)-1.
- One sub-module: ddr_burst_fifo.
  - Synchronous FIFO of depth 2^MAX_BURST_LOG2, width DATA_WIDTH + DATA_WIDTH/8.
  - Same clock and asynchronous reset as the parent.
  - Provides push, pop, full, empty and a count.

Test Plan:
- Reset, then local_ready_i = 1 -> idle_o = 1 on the second cycle; all req outputs = 0; local_size_o = 1.
- Write, buf_width_i = 2, adr_i = 0x104, data 0xA0..0xA3 -> 4 acks, then 4 write_req beats.
  - local_address_o = 0x40; local_size_o = 4.
  - burstbegin on beat 0 only; wdata = 0xA0..0xA3 in order.
- Same write with local_ready_i low on beats 1 and 2 -> each beat held until ready; no beat lost or duplicated.
- Read, buf_width_i = 3, adr_i = 0x220 -> read_req held 2 cycles under not-ready, with local_address_o = 0x88 and local_size_o = 8.
  - 8 valid beats give 8 acks with adr_o = 0x220..0x23C.
- Write fill with acc_i dropped after 2 of 4 beats -> short burst with local_size_o = 2 and exactly 2 write beats.
- Reset asserted during RDATA after 3 beats -> outputs return to reset values asynchronously; the next read after WAIT_READY completes normally.
